// File: rtl/ysram_row_writer.sv
// ysram_row_writer: read-modify-write of one 16-bit entry inside a 256-bit Y-SRAM row.
// Optional YSRAM_ACCUM_EN: merged entry = stored entry + update (mod 2^16) instead of replace.
module ysram_row_writer #(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned ROW_W    = 256,
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_row,
  input  logic [3:0]        upd_slot,
  input  logic [WORD_W-1:0] upd_value,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [ROW_W-1:0]  sram_wdata,
  input  logic [ROW_W-1:0]  sram_rdata,
  output logic              wr_done,
  output logic              busy,
  output logic [15:0]       upd_count
);

  localparam int unsigned SLOT_W    = 4;
  localparam int unsigned NUM_SLOTS = ROW_W / WORD_W;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned UCNT_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [ADDR_W-1:0] row_q;
  logic [SLOT_W-1:0] slot_q;
  logic [WORD_W-1:0] value_q;
  logic [ROW_W-1:0]  row_buf;
  logic [CNT_W-1:0]  wait_cnt;

  logic accept;
  logic wait_last;

  logic              ready_d;
  logic              busy_d;
  logic              rd_d;
  logic              wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ROW_W-1:0]  buf_d;
  logic [UCNT_W-1:0] count_d;

  logic [WORD_W-1:0] new_word;
  logic [ROW_W-1:0]  merged;

  assign accept    = upd_valid & upd_ready;
  assign wait_last = (wait_cnt == CNT_W'(READ_LAT - 1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_READ;
      S_READ:  next_state = S_WAIT;
      S_WAIT:  if (wait_last) next_state = S_WRITE;
      S_WRITE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Merge the latched update into the row arriving from the SRAM
`ifdef YSRAM_ACCUM_EN
  logic [WORD_W-1:0] old_word;

  always_comb begin
    old_word = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (slot_q == SLOT_W'(i)) old_word = sram_rdata[i*WORD_W +: WORD_W];
    end
    new_word = old_word + value_q;
  end
`else
  always_comb begin
    new_word = value_q;
  end
`endif

  always_comb begin
    merged = sram_rdata;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (slot_q == SLOT_W'(i)) merged[i*WORD_W +: WORD_W] = new_word;
    end
  end

  // Output logic: next values of the registered outputs, derived from next_state
  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = '0;
    buf_d   = '0;
    count_d = upd_count;
    case (next_state)
      S_IDLE: begin
        ready_d = 1'b1;
      end
      S_READ: begin
        busy_d = 1'b1;
        rd_d   = 1'b1;
        addr_d = upd_row;
      end
      S_WAIT: begin
        busy_d = 1'b1;
        addr_d = row_q;
      end
      S_WRITE: begin
        busy_d  = 1'b1;
        wr_d    = 1'b1;
        addr_d  = row_q;
        buf_d   = merged;
        count_d = upd_count + UCNT_W'(1);
      end
      default: begin
        ready_d = 1'b1;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      upd_ready  <= 1'b1;
      busy       <= 1'b0;
      sram_rd_en <= 1'b0;
      sram_wr_en <= 1'b0;
      wr_done    <= 1'b0;
      sram_addr  <= '0;
      row_buf    <= '0;
      upd_count  <= '0;
    end else begin
      upd_ready  <= ready_d;
      busy       <= busy_d;
      sram_rd_en <= rd_d;
      sram_wr_en <= wr_d;
      wr_done    <= wr_d;
      sram_addr  <= addr_d;
      row_buf    <= buf_d;
      upd_count  <= count_d;
    end
  end

  // Row buffer holds the merged row only during the write cycle, zero otherwise
  assign sram_wdata = row_buf;

  // Update latch and read-latency counter
  always_ff @(posedge clock) begin
    if (reset) begin
      row_q    <= '0;
      slot_q   <= '0;
      value_q  <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == S_IDLE && accept) begin
        row_q   <= upd_row;
        slot_q  <= upd_slot;
        value_q <= upd_value;
      end
      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  a_no_rd_wr_overlap: assert property (@(posedge clock) disable iff (reset)
    !(sram_rd_en && sram_wr_en));

  a_done_with_write: assert property (@(posedge clock) disable iff (reset)
    (sram_wr_en == wr_done));

endmodule

// File: tb/tb_ysram_row_writer.sv
// tb_ysram_row_writer: table vectors, hand sequences and random updates for ysram_row_writer.
// Build with +define+YSRAM_ACCUM_EN to check the accumulate variant; READ_LAT is a local parameter.
module tb_ysram_row_writer;

  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned ROW_W    = 256;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned READ_LAT = 1;
`ifdef YSRAM_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic              clock;
  logic              reset;
  logic              upd_valid;
  logic              upd_ready;
  logic [ADDR_W-1:0] upd_row;
  logic [3:0]        upd_slot;
  logic [WORD_W-1:0] upd_value;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_rd_en;
  logic              sram_wr_en;
  logic [ROW_W-1:0]  sram_wdata;
  logic [ROW_W-1:0]  sram_rdata;
  logic              wr_done;
  logic              busy;
  logic [15:0]       upd_count;

  ysram_row_writer #(
    .ADDR_W(ADDR_W), .ROW_W(ROW_W), .WORD_W(WORD_W), .READ_LAT(READ_LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_row(upd_row), .upd_slot(upd_slot), .upd_value(upd_value),
    .sram_addr(sram_addr), .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .wr_done(wr_done), .busy(busy), .upd_count(upd_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM model: data valid exactly READ_LAT cycles after the read strobe, random garbage otherwise
  logic [ROW_W-1:0]  mem [2**ADDR_W];
  logic [ADDR_W:0]   pipe [READ_LAT];
  logic [ROW_W-1:0]  garbage = '0;
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [ROW_W-1:0]  pl_data;
  int                wr_pulses = 0;
  bit                both_seen = 1'b0;
  int                cyc = 0;

  assign sram_rdata = pipe[READ_LAT-1][ADDR_W] ? mem[pipe[READ_LAT-1][ADDR_W-1:0]] : garbage;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    garbage <= {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (reset) begin
      for (int i = 0; i < int'(READ_LAT); i++) pipe[i] <= '0;
    end else begin
      for (int i = int'(READ_LAT) - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= {sram_rd_en, sram_addr};
    end
    if (pl_en) mem[pl_addr] <= pl_data;
    if (sram_wr_en) begin
      mem[sram_addr] <= sram_wdata;
      wr_pulses <= wr_pulses + 1;
    end
    if (sram_rd_en && sram_wr_en) both_seen <= 1'b1;
  end

  // Reference state: golden row contents and completed-write count
  logic [ROW_W-1:0] ref_mem [2**ADDR_W];
  logic [15:0]      exp_count;
  int               n_cmp;
  int               n_bad;

  typedef struct {
    logic [ADDR_W-1:0] row;
    logic [3:0]        slot;
    logic [WORD_W-1:0] val;
    logic [WORD_W-1:0] fill;
    logic [WORD_W-1:0] exp_rep;
    logic [WORD_W-1:0] exp_acc;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [ROW_W-1:0] merge(input logic [ROW_W-1:0] old, input logic [3:0] slot,
                                             input logic [WORD_W-1:0] v);
    logic [ROW_W-1:0]  r;
    logic [WORD_W-1:0] w;
    r = old;
    w = old[int'(slot)*16 +: 16];
    r[int'(slot)*16 +: 16] = ACC ? (w + v) : v;
    return r;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called and returns at a falling edge
  task automatic preload(input logic [ADDR_W-1:0] a, input logic [ROW_W-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clock);
    #1 pl_en = 1'b0;
    ref_mem[a] = d;
    @(negedge clock);
  endtask

  // One full update with cycle-by-cycle checks; called and returns at a falling edge
  task automatic do_update(input logic [ADDR_W-1:0] row, input logic [3:0] slot,
                           input logic [WORD_W-1:0] val, output logic [ROW_W-1:0] wd);
    logic [ROW_W-1:0] exp;
    int waited;
    waited = 0;
    wd = '0;
    while (!upd_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    chk1("ready_before_accept", upd_ready, 1'b1);
    exp = merge(ref_mem[row], slot, val);
    ref_mem[row] = exp;
    exp_count = exp_count + 16'd1;
    upd_valid = 1'b1;
    upd_row   = row;
    upd_slot  = slot;
    upd_value = val;
    @(posedge clock);
    #1;
    upd_valid = 1'b0;
    upd_row   = ADDR_W'($urandom);
    upd_slot  = 4'($urandom);
    upd_value = WORD_W'($urandom);
    for (int k = 1; k <= int'(READ_LAT) + 2; k++) begin
      @(negedge clock);
      if (k == 1) begin
        chk1("rd_en_read", sram_rd_en, 1'b1);
        chk1("ready_busy", upd_ready, 1'b0);
        chk1("busy_read", busy, 1'b1);
      end else begin
        chk1("rd_en_low", sram_rd_en, 1'b0);
      end
      chkv("addr", ROW_W'(sram_addr), ROW_W'(row));
      chk1("wr_en_timing", sram_wr_en, k == int'(READ_LAT) + 2);
      if (k == int'(READ_LAT) + 2) begin
        chk1("wr_done", wr_done, 1'b1);
        chkv("wdata_model", sram_wdata, exp);
        wd = sram_wdata;
      end
    end
    @(negedge clock);
    chk1("ready_after", upd_ready, 1'b1);
    chk1("busy_after", busy, 1'b0);
    chk1("wr_done_after", wr_done, 1'b0);
    chkv("wdata_zero", sram_wdata, '0);
    chkv("count", ROW_W'(upd_count), ROW_W'(exp_count));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ROW_W-1:0] wd;
    logic [ROW_W-1:0] exp_row;
    logic [ROW_W-1:0] expq [$];
    logic [ADDR_W-1:0] expa [$];
    logic [ADDR_W-1:0] h_row [3];
    logic [3:0]        h_slot [3];
    logic [WORD_W-1:0] h_val [3];
    int acc_cyc [3];
    int nacc, nwr, idx, wp0;
    bit accepted;

    n_cmp = 0;
    n_bad = 0;
    exp_count = '0;
    reset = 1'b1;
    upd_valid = 1'b0;
    upd_row = '0;
    upd_slot = '0;
    upd_value = '0;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;

    tbl[0] = '{row: 11'h005, slot: 4'd3,  val: 16'hBEEF, fill: 16'h1111, exp_rep: 16'hBEEF, exp_acc: 16'hD000};
    tbl[1] = '{row: 11'h006, slot: 4'd0,  val: 16'h0020, fill: 16'hFFF0, exp_rep: 16'h0020, exp_acc: 16'h0010};
    tbl[2] = '{row: 11'h006, slot: 4'd15, val: 16'h0002, fill: 16'h0001, exp_rep: 16'h0002, exp_acc: 16'h0003};
    tbl[3] = '{row: 11'h7FF, slot: 4'd8,  val: 16'hFFFF, fill: 16'h0001, exp_rep: 16'hFFFF, exp_acc: 16'h0000};
    tbl[4] = '{row: 11'h000, slot: 4'd1,  val: 16'h1234, fill: 16'hA5A5, exp_rep: 16'h1234, exp_acc: 16'hB7D9};
    tbl[5] = '{row: 11'h400, slot: 4'd7,  val: 16'h8000, fill: 16'h8000, exp_rep: 16'h8000, exp_acc: 16'h0000};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) @(negedge clock);
    chk1("rst_ready", upd_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rd_en", sram_rd_en, 1'b0);
    chk1("rst_wr_en", sram_wr_en, 1'b0);
    chk1("rst_wr_done", wr_done, 1'b0);
    chkv("rst_addr", ROW_W'(sram_addr), '0);
    chkv("rst_wdata", sram_wdata, '0);
    chkv("rst_count", ROW_W'(upd_count), '0);

    // Directed vectors, expected words worked out by hand
    for (int i = 0; i < 6; i++) begin
      preload(tbl[i].row, {16{tbl[i].fill}});
      do_update(tbl[i].row, tbl[i].slot, tbl[i].val, wd);
      exp_row = {16{tbl[i].fill}};
      exp_row[int'(tbl[i].slot)*16 +: 16] = ACC ? tbl[i].exp_acc : tbl[i].exp_rep;
      chkv("tbl_slot_word", ROW_W'(wd[int'(tbl[i].slot)*16 +: 16]),
           ROW_W'(ACC ? tbl[i].exp_acc : tbl[i].exp_rep));
      chkv("tbl_row", wd, exp_row);
    end

    // upd_valid held high across three updates (two to the same row)
    preload(11'h010, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    preload(11'h011, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    h_row[0] = 11'h010; h_slot[0] = 4'd2; h_val[0] = WORD_W'($urandom);
    h_row[1] = 11'h010; h_slot[1] = 4'd5; h_val[1] = WORD_W'($urandom);
    h_row[2] = 11'h011; h_slot[2] = 4'd2; h_val[2] = WORD_W'($urandom);
    nacc = 0;
    nwr = 0;
    idx = 0;
    upd_valid = 1'b1;
    upd_row = h_row[0];
    upd_slot = h_slot[0];
    upd_value = h_val[0];
    for (int c = 0; c < 40 && nwr < 3; c++) begin
      chk1("ready_vs_busy", upd_ready, !busy);
      if (sram_wr_en) begin
        if (expq.size() > 0) begin
          chkv("hold_addr", ROW_W'(sram_addr), ROW_W'(expa.pop_front()));
          chkv("hold_wdata", sram_wdata, expq.pop_front());
        end else begin
          n_cmp++;
          n_bad++;
          $display("FAIL hold_unexpected_write: addr %h", sram_addr);
        end
        nwr++;
      end
      accepted = upd_valid && upd_ready;
      if (accepted) begin
        ref_mem[upd_row] = merge(ref_mem[upd_row], upd_slot, upd_value);
        expq.push_back(ref_mem[upd_row]);
        expa.push_back(upd_row);
        exp_count = exp_count + 16'd1;
        if (nacc < 3) acc_cyc[nacc] = cyc;
        nacc++;
      end
      @(posedge clock);
      #1;
      if (accepted) begin
        idx++;
        if (idx < 3) begin
          upd_row = h_row[idx];
          upd_slot = h_slot[idx];
          upd_value = h_val[idx];
        end else begin
          upd_valid = 1'b0;
        end
      end
      @(negedge clock);
    end
    chkv("hold_accepts", ROW_W'(nacc), ROW_W'(3));
    chkv("hold_writes", ROW_W'(nwr), ROW_W'(3));
    chkv("hold_spacing_1", ROW_W'(acc_cyc[1] - acc_cyc[0]), ROW_W'(READ_LAT + 3));
    chkv("hold_spacing_2", ROW_W'(acc_cyc[2] - acc_cyc[1]), ROW_W'(READ_LAT + 3));
    upd_valid = 1'b0;
    @(negedge clock);
    chkv("hold_count", ROW_W'(upd_count), ROW_W'(exp_count));

    // Reset while waiting for read data: the update is dropped, nothing is written
    preload(11'h020, {16{16'h5A5A}});
    wp0 = wr_pulses;
    upd_valid = 1'b1;
    upd_row = 11'h020;
    upd_slot = 4'd9;
    upd_value = 16'h0BAD;
    @(posedge clock);
    #1 upd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk1("wait_state_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    exp_count = '0;
    @(negedge clock);
    chk1("midrst_ready", upd_ready, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_rd_en", sram_rd_en, 1'b0);
    chkv("midrst_addr", ROW_W'(sram_addr), '0);
    chkv("midrst_count", ROW_W'(upd_count), '0);
    repeat (READ_LAT + 3) @(negedge clock);
    chkv("midrst_no_write", ROW_W'(wr_pulses), ROW_W'(wp0));
    do_update(11'h020, 4'd9, 16'h0BAD, wd);
    exp_row = {16{16'h5A5A}};
    exp_row[9*16 +: 16] = ACC ? 16'h6607 : 16'h0BAD;
    chkv("midrst_fresh_row", wd, exp_row);

    // Random updates over a few rows so same-row read-after-write is exercised
    for (int r = 0; r < 4; r++) begin
      preload(ADDR_W'(11'h100 + r),
              {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    end
    for (int n = 0; n < 30; n++) begin
      do_update(ADDR_W'(11'h100 + $urandom_range(0, 3)), 4'($urandom), WORD_W'($urandom), wd);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    chk1("rd_wr_overlap", both_seen, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
